// File: rtl/typing_round_counter.sv
// Typing-test round controller: BCD countdown, word counter and 2-digit display source.
// Optional build macro BLANK_LEAD_ZERO_EN blanks a leading zero on the tens digit.
module typing_round_counter #(
  parameter int CLK_HZ    = 100000000,
  parameter int ROUND_SEC = 60,
  parameter int MUX_HZ    = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       word_ok,
  output logic [3:0] digit_one,
  output logic [3:0] digit_two,
  output logic       one_en,
  output logic       two_en,
  output logic       ssd_clk,
  output logic       round_done
);

  localparam int MUX_DIV_RAW = CLK_HZ / (2 * MUX_HZ);
  localparam int MUX_DIV     = (MUX_DIV_RAW < 1) ? 1 : MUX_DIV_RAW;
  localparam int PW          = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int MW          = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;

  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [MW-1:0] MUX_MAX   = MW'(MUX_DIV - 1);
  localparam logic [7:0]    ROUND_BCD = {4'(ROUND_SEC / 10), 4'(ROUND_SEC % 10)};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [7:0]    secs, secs_nxt;
  logic [7:0]    words, words_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic [MW-1:0] mux_cnt;
  logic          sec_tick;
  logic [7:0]    disp_val;
  logic          one_en_nxt;

  // Saturating BCD increment: 99 holds.
  function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
    if (v == 8'h99)
      return v;
    if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // BCD decrement with borrow; never applied to 00.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0)
      return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  assign sec_tick = (state == RUN) && (presc == PRESC_MAX);

  always_comb begin
    state_nxt = state;
    secs_nxt  = secs;
    words_nxt = words;
    presc_nxt = '0;
    if (start) begin
      state_nxt = RUN;
      secs_nxt  = ROUND_BCD;
      words_nxt = 8'h00;
    end else begin
      case (state)
        RUN: begin
          presc_nxt = sec_tick ? '0 : presc + PW'(1);
          if (word_ok)
            words_nxt = bcd_inc_sat(words);
          if (sec_tick) begin
            if (secs == 8'h01) begin
              secs_nxt  = 8'h00;
              state_nxt = DONE;
            end else begin
              secs_nxt = bcd_dec(secs);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    disp_val = (state == DONE) ? words : secs;
`ifdef BLANK_LEAD_ZERO_EN
    one_en_nxt = (disp_val[7:4] != 4'd0) || ((state == DONE) && (words == 8'h00));
`else
    one_en_nxt = 1'b1;
`endif
  end

  // Control and counter state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      secs       <= ROUND_BCD;
      words      <= 8'h00;
      presc      <= '0;
      round_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      secs       <= secs_nxt;
      words      <= words_nxt;
      presc      <= presc_nxt;
      round_done <= (state_nxt == DONE);
    end
  end

  // Display registers, one cycle behind their source
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_one <= ROUND_BCD[7:4];
      digit_two <= ROUND_BCD[3:0];
      one_en    <= 1'b1;
      two_en    <= 1'b1;
    end else begin
      digit_one <= disp_val[7:4];
      digit_two <= disp_val[3:0];
      one_en    <= one_en_nxt;
      two_en    <= 1'b1;
    end
  end

  // Free-running multiplex clock divider
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mux_cnt <= '0;
      ssd_clk <= 1'b0;
    end else if (mux_cnt == MUX_MAX) begin
      mux_cnt <= '0;
      ssd_clk <= ~ssd_clk;
    end else begin
      mux_cnt <= mux_cnt + MW'(1);
    end
  end

endmodule

// File: doc/typing_round_counter.md
Name: typing_round_counter

Overview:
- Round controller and score source for the typing test; sits directly upstream of the two-digit seven-segment display driver.
- Runs a fixed-length countdown round and counts correct words typed during it.
- Presents the active value as two BCD digits with per-digit enables, and generates the display's multiplex clock.
- Shows remaining seconds while a round runs and the final word count (words per round) after it ends.

Parameters:
- CLK_HZ, 100000000, input clock frequency in Hz.
- ROUND_SEC, 60, round length in seconds; legal range 1..99.
- MUX_HZ, 500, display multiplex toggle rate in Hz; ssd_clk period = 2 toggles.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; begins a new round from any state.
- word_ok  input  1  single-cycle pulse; one correctly typed word.
- digit_one  output  4  BCD tens digit to display.
- digit_two  output  4  BCD ones digit to display.
- one_en  output  1  tens digit enable.
- two_en  output  1  ones digit enable.
- ssd_clk  output  1  square-wave multiplex clock for the display (its fast_clk).
- round_done  output  1  high while in DONE.

Behaviour:
- One clock. Reset is asynchronous, active-low. All state and outputs are registered on clk.
- Reset values:
  - state=IDLE; secs=ROUND_SEC in BCD; words=00; prescaler=0; mux divider=0.
  - ssd_clk=0; round_done=0.
  - digit_one/digit_two = ROUND_SEC tens/ones; one_en=two_en=1.
- Prescaler:
  - Counts 0..CLK_HZ-1 while in RUN.
  - sec_tick is a 1-cycle pulse when the count equals CLK_HZ-1, then the count wraps to 0.
  - Cleared to 0 on start and outside RUN.
- Mux divider:
  - Free-running; toggles ssd_clk every CLK_HZ/(2*MUX_HZ) cycles, in all states.
  - Never stops; reset drives it to 0.
- FSM:
  - IDLE: display secs (=ROUND_SEC). On start -> RUN.
  - RUN: display secs.
    - On sec_tick, BCD-decrement secs: ones 0 -> 9 with a borrow from tens.
    - On sec_tick with secs==01 -> secs=00, state -> DONE.
  - DONE: display words; round_done=1. On start -> RUN.
- start (any state): next cycle state=RUN, secs=ROUND_SEC, words=00, prescaler=0. start has priority over sec_tick and word_ok in the same cycle.
- word_ok:
  - Counted only when state==RUN, including the cycle in which the final sec_tick occurs.
  - Ignored in IDLE and DONE.
  - BCD increment: ones 9 -> 0 with a carry into tens.
  - Saturates at 99; further pulses have no effect.
- Display registers:
  - digit_one/digit_two/one_en/two_en update one cycle after the selected source value or state changes.
  - Non-BCD codes are never produced.
- Reset mid-round: returns immediately to IDLE with reset values; no partial count retained.

Optional Feature:
- Macro BLANK_LEAD_ZERO_EN.
- Defined:
  - one_en=0 whenever the displayed tens digit is 0; two_en stays 1.
  - Exception: in DONE with words==00, both enables are 1 ("00" shown).
- Undefined: one_en=two_en=1 in all states; leading zeros are displayed.

Test Plan:
- Reset: hold rst_n=0 mid-RUN with secs=42, release -> state IDLE, digits 6/0, words=0, ssd_clk=0, round_done=0.
- Countdown with CLK_HZ=10, ROUND_SEC=12: start -> digits 1/2, then 1/1 after 10 cycles, then 1/0, then 0/9 (borrow). After 120 cycles round_done=1 and the digits show the word count.
- Word count: 23 word_ok pulses during RUN -> DONE shows 2/3. 105 pulses -> saturates at 9/9. word_ok in IDLE or DONE -> count unchanged.
- Simultaneous events: start and word_ok in the same cycle during RUN -> words=00 and secs=ROUND_SEC. word_ok coincident with the final sec_tick -> counted.
- Mux clock with CLK_HZ=100, MUX_HZ=10: ssd_clk toggles every 5 cycles (period 10) in IDLE, RUN and DONE.
- BLANK_LEAD_ZERO_EN defined:
  - secs=07 -> one_en=0, two_en=1.
  - DONE with words=00 -> one_en=1, two_en=1.
  - Macro undefined, secs=07 -> one_en=1.
